// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, exception codes and default sizes for the execute unit
package exec_pkg;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    PASS = 4'd4,
    EQ   = 4'd5,
    MUL  = 4'd6
  } alu_op_t;
  localparam logic [3:0] EXC_NONE       = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL_OP = 4'd1;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_MUL_STAGES = 5;
  localparam int DEF_TAG_W      = 4;
endpackage

// File: rtl/exec_alu_pipe_if.sv
// exec_alu_pipe_if: issue and result handshake buses of the execute unit
interface exec_alu_pipe_if #(parameter int WIDTH = 32, parameter int TAG_W = 4);
  logic               in_valid;
  logic               in_ready;
  exec_pkg::alu_op_t  in_op;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic               out_zero;
  logic               out_exc;
  logic [3:0]         out_exc_code;
  logic [TAG_W-1:0]   out_tag;
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_exc, out_exc_code, out_tag
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_exc, out_exc_code, out_tag
  );
endinterface

// File: rtl/exec_alu_pipe_mul_pipe.sv
// mul_pipe: multiplier shift pipeline; the output register acts as its last stage
module mul_pipe #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 5,
  parameter int TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag,
  output logic             done_valid,
  output logic [WIDTH-1:0] done_prod,
  output logic             done_zero,
  output logic [TAG_W-1:0] done_tag,
  output logic             any_valid
);
  localparam int D = MUL_STAGES - 1;
  logic [WIDTH-1:0] prod;
  assign prod = a * b;
  if (D == 0) begin : g_comb
    assign done_valid = in_valid;
    assign done_prod  = prod;
    assign done_zero  = a == b;
    assign done_tag   = tag;
    assign any_valid  = 1'b0;
  end else begin : g_pipe
    logic [D-1:0]     v;
    logic [D-1:0]     z;
    logic [WIDTH-1:0] p [D];
    logic [TAG_W-1:0] t [D];
    always_ff @(posedge clk)
      if (rst) begin
        v <= '0;
        z <= '0;
        for (int i = 0; i < D; i++) begin
          p[i] <= '0;
          t[i] <= '0;
        end
      end else begin
        if (en) begin
          v[0] <= in_valid;
          z[0] <= a == b;
          p[0] <= prod;
          t[0] <= tag;
          for (int i = 1; i < D; i++) begin
            v[i] <= v[i-1];
            z[i] <= z[i-1];
            p[i] <= p[i-1];
            t[i] <= t[i-1];
          end
        end
        if (clr) v <= '0;
      end
    assign done_valid = v[D-1];
    assign done_prod  = p[D-1];
    assign done_zero  = z[D-1];
    assign done_tag   = t[D-1];
    assign any_valid  = |v;
  end
endmodule

// File: rtl/exec_alu_pipe.sv
// exec_alu_pipe: pipelined EX-stage ALU with in-order single-cycle and multiplier paths
module exec_alu_pipe import exec_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_STAGES = DEF_MUL_STAGES,
  parameter int TAG_W      = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  exec_alu_pipe_if.slave    bus
);
  logic             stall, is_mul, mul_busy, acc, sc_acc;
  logic             done_v, done_z, sc_exc;
  logic [WIDTH-1:0] done_p, sc_res;
  logic [TAG_W-1:0] done_tag;
  assign stall  = bus.out_valid && !bus.out_ready;
  assign is_mul = bus.in_op == MUL;
  // single-cycle ops wait for the multiplier to drain so results stay in order
  assign bus.in_ready = !rst && !flush && !stall && !(!is_mul && mul_busy);
  assign acc    = bus.in_valid && bus.in_ready;
  assign sc_acc = acc && !is_mul;
  always_comb begin
    sc_exc = 1'b0;
    sc_res = '0;
    case (bus.in_op)
      ADD:     sc_res = bus.in_a + bus.in_b;
      SUB:     sc_res = bus.in_a - bus.in_b;
      AND:     sc_res = bus.in_a & bus.in_b;
      OR:      sc_res = bus.in_a | bus.in_b;
      PASS:    sc_res = bus.in_a;
      EQ:      sc_res = '0;
      default: sc_exc = !is_mul;
    endcase
  end
  mul_pipe #(.WIDTH(WIDTH), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) u_mul (
    .clk(clk),
    .rst(rst),
    .clr(rst || flush),
    .en(!stall),
    .in_valid(acc && is_mul),
    .a(bus.in_a),
    .b(bus.in_b),
    .tag(bus.in_tag),
    .done_valid(done_v),
    .done_prod(done_p),
    .done_zero(done_z),
    .done_tag(done_tag),
    .any_valid(mul_busy)
  );
  always_ff @(posedge clk)
    if (rst) begin
      bus.out_valid    <= 1'b0;
      bus.out_result   <= '0;
      bus.out_zero     <= 1'b0;
      bus.out_exc      <= 1'b0;
      bus.out_exc_code <= EXC_NONE;
      bus.out_tag      <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (!stall) begin
      bus.out_valid <= done_v || sc_acc;
      if (done_v || sc_acc) begin
        bus.out_result   <= done_v ? done_p : sc_res;
        bus.out_zero     <= done_v ? done_z : bus.in_a == bus.in_b;
        bus.out_exc      <= !done_v && sc_exc;
        bus.out_exc_code <= (!done_v && sc_exc) ? EXC_ILLEGAL_OP : EXC_NONE;
        bus.out_tag      <= done_v ? done_tag : bus.in_tag;
      end
    end
endmodule
